sprite_motion: RTL and testbench
================================

Name: sprite_motion

Overview:
- Per-frame motion and animation sequencer for up to NSPR hardware sprites.
- On each `frame` pulse it walks a register file of sprite state, one sprite per cycle. For each sprite it applies velocity, applies a wrap or bounce rule at the screen edges, and advances the animation frame index.
- Positions are exposed through a registered read port. The top level feeds them to the `sprx`/`spry` inputs of the sprite instances.
- Replaces the ad-hoc per-top position logic.

Parameters:
- CORDW, 16, signed coordinate width (bits).
- NSPR, 4, number of sprites (≥2).
- IDW, $clog2(NSPR), sprite index width.
- VELW, 8, signed velocity width (pixels/frame).
- H_RES, 1280, horizontal resolution.
- V_RES, 720, vertical resolution.
- SPR_DRAWW, 256, drawn sprite width (pixels).
- SPR_DRAWH, 160, drawn sprite height (pixels).
- ANIM_FRAMES, 4, animation frames per sprite.
- ANIM_DIV, 8, display frames per animation step.

Ports:
- clk_pix  in  1  pixel clock.
- rst_pix  in  1  synchronous active-high reset.
- frame  in  1  start-of-frame pulse from the display timing block.
- cfg_we  in  1  configuration write strobe.
- cfg_id  in  IDW  sprite to configure.
- cfg_x  in  CORDW  signed initial x.
- cfg_y  in  CORDW  signed initial y.
- cfg_vx  in  VELW  signed x velocity.
- cfg_vy  in  VELW  signed y velocity.
- cfg_bounce  in  1  edge rule: 0 = wrap, 1 = bounce.
- rd_id  in  IDW  sprite to read.
- rd_x  out  CORDW  signed x of rd_id.
- rd_y  out  CORDW  signed y of rd_id.
- rd_anim  out  $clog2(ANIM_FRAMES)  animation frame index of rd_id.
- busy  out  1  update sweep in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- overrun  out  1  sticky: a frame pulse arrived while busy.

Behaviour:
- Reset values, every sprite:
  - x = H_RES, y = 0, vx = vy = 0, bounce = 0, anim = 0.
  - Frame divider = 0.
- Reset values, outputs:
  - rd_x = H_RES, rd_y = 0, rd_anim = 0.
  - busy = done = overrun = 0.
- Reset mid-sweep aborts the sweep immediately; reset values are applied on the next edge.
- FSM states: IDLE, SWEEP, FIN.
  - IDLE → SWEEP on `frame`. idx <= 0, busy <= 1.
  - SWEEP updates sprite idx each cycle, then idx++. After idx = NSPR-1 → FIN.
  - FIN: done = 1 for one cycle, busy <= 0, → IDLE.
  - Sweep length: busy high NSPR+1 cycles. done asserts NSPR+1 cycles after the frame edge.
- Frame divider:
  - Increments once per accepted frame.
  - On reaching ANIM_DIV-1 it wraps to 0 and sets an anim_step flag for that sweep.
  - On anim_step, each swept sprite gets anim <= (anim+1) mod ANIM_FRAMES.
- Arithmetic:
  - Velocity is sign-extended to CORDW; nx = x + vx, ny = y + vy, in CORDW+1 bits with no overflow.
- Wrap rule, x:
  - nx ≤ -SPR_DRAWW → x = H_RES.
  - nx ≥ H_RES+1 → x = -SPR_DRAWW+1.
  - Otherwise x = nx.
- Wrap rule, y: same form using V_RES and SPR_DRAWH.
- Bounce rule, x:
  - nx < 0 → x = 0, vx = -vx.
  - nx > H_RES-SPR_DRAWW → x = H_RES-SPR_DRAWW, vx = -vx.
  - Otherwise x = nx.
- Bounce rule, y: same form using V_RES and SPR_DRAWH.
- Velocity negation: vx = -2^(VELW-1) negates to +2^(VELW-1)-1 (saturating).
- Configuration writes:
  - cfg_we is accepted in any state and takes effect next edge.
  - It loads x, y, vx, vy, bounce and clears anim for sprite cfg_id.
  - If cfg_id equals the sprite being swept that cycle, the config write wins and that sprite's sweep update is discarded.
- Frame pulse handling:
  - `frame` while busy is ignored: divider not advanced, overrun <= 1.
  - overrun is cleared only by reset.
  - `frame` in the FIN cycle also counts as overrun.
- Read port:
  - 1-cycle latency: rd_* reflect sprite rd_id as stored at the previous edge.
  - Reads during a sweep may return pre- or post-update values per sprite. Consumers sample after done or during blanking.

Test Plan:
1. Reset, cfg sprite 0 (x=100, y=320, vx=-4, vy=0, wrap), one `frame` → busy high 5 cycles, done pulses once, rd_id=0 gives x=96, y=320.
2. Wrap: sprite 1 x=-252, vx=-4, wrap, one frame → x=1280. Then vx=+8 from x=1276 → x=-255.
3. Bounce: sprite 2 x=1020, vx=+8, bounce → x=1024, vx=-8. Next frame → x=1016. Sprite 2 y=2, vy=-5 → y=0, vy=+5.
4. Animation: 16 frames with ANIM_DIV=8 → anim of all sprites = 2. 8 more frames → 3. 8 more → 0 (mod 4).
5. Overrun and collision:
   - `frame` asserted on cycle 2 of a sweep → ignored, overrun=1, no extra done.
   - cfg_we for sprite 1 in the same cycle sprite 1 is swept → stored x equals cfg_x exactly, anim = 0.
6. Reset mid-sweep (cycle 2) → busy=0, done never pulses, all sprites at x=1280, y=0, overrun=0.

Source files
------------

// File: rtl/sprite_motion.sv
// sprite_motion: per-frame sprite motion/animation sweep (clk_pix/rst_pix, frame in, cfg_* write port, rd_* registered read, busy/done/overrun status)
module sprite_motion #(
  parameter int CORDW = 16,
  parameter int NSPR = 4,
  parameter int IDW = $clog2(NSPR),
  parameter int VELW = 8,
  parameter int H_RES = 1280,
  parameter int V_RES = 720,
  parameter int SPR_DRAWW = 256,
  parameter int SPR_DRAWH = 160,
  parameter int ANIM_FRAMES = 4,
  parameter int ANIM_DIV = 8
) (
  input  logic clk_pix,
  input  logic rst_pix,
  input  logic frame,
  input  logic cfg_we,
  input  logic [IDW-1:0] cfg_id,
  input  logic signed [CORDW-1:0] cfg_x,
  input  logic signed [CORDW-1:0] cfg_y,
  input  logic signed [VELW-1:0] cfg_vx,
  input  logic signed [VELW-1:0] cfg_vy,
  input  logic cfg_bounce,
  input  logic [IDW-1:0] rd_id,
  output logic signed [CORDW-1:0] rd_x,
  output logic signed [CORDW-1:0] rd_y,
  output logic [$clog2(ANIM_FRAMES)-1:0] rd_anim,
  output logic busy,
  output logic done,
  output logic overrun
);
  localparam int AW = $clog2(ANIM_FRAMES);
  localparam int DVW = $clog2(ANIM_DIV);
  localparam int PW = CORDW + 1;
  localparam logic signed [CORDW:0] HR = PW'(H_RES);
  localparam logic signed [CORDW:0] VR = PW'(V_RES);
  localparam logic signed [CORDW:0] SW = PW'(SPR_DRAWW);
  localparam logic signed [CORDW:0] SH = PW'(SPR_DRAWH);
  localparam logic signed [CORDW:0] XW = PW'(1 - SPR_DRAWW);
  localparam logic signed [CORDW:0] YW = PW'(1 - SPR_DRAWH);
  typedef enum logic [1:0] {IDLE, SWEEP, FIN} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] idx_q, idx_d;
  logic [DVW-1:0] div_q, div_d;
  logic step_q, step_d, overrun_q, overrun_d, go;
  logic signed [CORDW-1:0] x_q [NSPR];
  logic signed [CORDW-1:0] y_q [NSPR];
  logic signed [VELW-1:0] vx_q [NSPR];
  logic signed [VELW-1:0] vy_q [NSPR];
  logic bnc_q [NSPR];
  logic [AW-1:0] anim_q [NSPR];
  logic signed [CORDW-1:0] px, py, rd_x_q, rd_y_q;
  logic signed [VELW-1:0] pvx, pvy;
  logic [AW-1:0] pa, rd_anim_q;
  function automatic logic [CORDW+VELW-1:0] move(
    input logic signed [CORDW-1:0] p,
    input logic signed [VELW-1:0] v,
    input logic b,
    input logic signed [CORDW:0] res,
    input logic signed [CORDW:0] drw,
    input logic signed [CORDW:0] wmin
  );
    logic signed [CORDW:0] n, bmax;
    logic signed [VELW-1:0] nv;
    logic lo, hi;
    n = {p[CORDW-1], p} + {{(CORDW+1-VELW){v[VELW-1]}}, v};
    bmax = res - drw;
    // the most negative velocity has no positive twin, so it saturates
    nv = v == {1'b1, {(VELW-1){1'b0}}} ? {1'b0, {(VELW-1){1'b1}}} : -v;
    lo = b ? n[CORDW] : n <= -drw;
    hi = b ? n > bmax : n > res;
    move = {lo ? (b ? '0 : res[CORDW-1:0]) : hi ? (b ? bmax[CORDW-1:0] : wmin[CORDW-1:0]) : n[CORDW-1:0],
            (b && (lo || hi)) ? nv : v};
  endfunction
  assign go = state_q == IDLE && frame;
  always_comb begin
    state_d = state_q == IDLE ? (frame ? SWEEP : IDLE) : state_q == SWEEP ? (idx_q == IDW'(NSPR-1) ? FIN : SWEEP) : IDLE;
    idx_d = state_q == SWEEP ? idx_q + 1'b1 : '0;
    div_d = go ? (div_q == DVW'(ANIM_DIV-1) ? '0 : div_q + 1'b1) : div_q;
    step_d = go ? div_q == DVW'(ANIM_DIV-1) : step_q;
    overrun_d = overrun_q | (frame && state_q != IDLE);
    {px, pvx} = move(x_q[idx_q], vx_q[idx_q], bnc_q[idx_q], HR, SW, XW);
    {py, pvy} = move(y_q[idx_q], vy_q[idx_q], bnc_q[idx_q], VR, SH, YW);
    pa = step_q ? (anim_q[idx_q] == AW'(ANIM_FRAMES-1) ? '0 : anim_q[idx_q] + 1'b1) : anim_q[idx_q];
  end
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state_q <= IDLE;
      idx_q <= '0;
      div_q <= '0;
      step_q <= 1'b0;
      overrun_q <= 1'b0;
      rd_x_q <= HR[CORDW-1:0];
      rd_y_q <= '0;
      rd_anim_q <= '0;
      for (int i = 0; i < NSPR; i++) begin
        x_q[i] <= HR[CORDW-1:0];
        y_q[i] <= '0;
        vx_q[i] <= '0;
        vy_q[i] <= '0;
        bnc_q[i] <= 1'b0;
        anim_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      div_q <= div_d;
      step_q <= step_d;
      overrun_q <= overrun_d;
      rd_x_q <= x_q[rd_id];
      rd_y_q <= y_q[rd_id];
      rd_anim_q <= anim_q[rd_id];
      if (state_q == SWEEP) begin
        x_q[idx_q] <= px;
        y_q[idx_q] <= py;
        vx_q[idx_q] <= pvx;
        vy_q[idx_q] <= pvy;
        anim_q[idx_q] <= pa;
      end
      // placed after the sweep update so a colliding config write wins
      if (cfg_we) begin
        x_q[cfg_id] <= cfg_x;
        y_q[cfg_id] <= cfg_y;
        vx_q[cfg_id] <= cfg_vx;
        vy_q[cfg_id] <= cfg_vy;
        bnc_q[cfg_id] <= cfg_bounce;
        anim_q[cfg_id] <= '0;
      end
    end
  end
  assign rd_x = rd_x_q;
  assign rd_y = rd_y_q;
  assign rd_anim = rd_anim_q;
  assign busy = state_q != IDLE;
  assign done = state_q == FIN;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_sprite_motion.sv
// tb_sprite_motion: directed self-checking bench for sprite_motion
module tb_sprite_motion;
  localparam int CORDW = 16;
  localparam int NSPR = 4;
  localparam int IDW = 2;
  localparam int VELW = 8;
  logic clk_pix = 1'b0;
  logic rst_pix = 1'b1;
  logic frame = 1'b0;
  logic cfg_we = 1'b0;
  logic [IDW-1:0] cfg_id = '0;
  logic signed [CORDW-1:0] cfg_x = '0;
  logic signed [CORDW-1:0] cfg_y = '0;
  logic signed [VELW-1:0] cfg_vx = '0;
  logic signed [VELW-1:0] cfg_vy = '0;
  logic cfg_bounce = 1'b0;
  logic [IDW-1:0] rd_id = '0;
  logic signed [CORDW-1:0] rd_x, rd_y;
  logic [1:0] rd_anim;
  logic busy, done, overrun;
  int checks = 0;
  int failures = 0;
  int nb, nd;
  sprite_motion dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .frame(frame), .cfg_we(cfg_we), .cfg_id(cfg_id),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_vx(cfg_vx), .cfg_vy(cfg_vy), .cfg_bounce(cfg_bounce),
    .rd_id(rd_id), .rd_x(rd_x), .rd_y(rd_y), .rd_anim(rd_anim), .busy(busy), .done(done),
    .overrun(overrun)
  );
  always #5 clk_pix = ~clk_pix;
  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic cfg(input int id, input int x, input int y, input int vx, input int vy, input bit b);
    cfg_we = 1'b1;
    cfg_id = IDW'(id);
    cfg_x = CORDW'(x);
    cfg_y = CORDW'(y);
    cfg_vx = VELW'(vx);
    cfg_vy = VELW'(vy);
    cfg_bounce = b;
    tick();
    cfg_we = 1'b0;
  endtask
  task automatic rd(input int id);
    rd_id = IDW'(id);
    tick();
  endtask
  task automatic watch(input int n);
    nb = 0;
    nd = 0;
    for (int i = 0; i < n; i++) begin
      nb += int'(busy);
      nd += int'(done);
      tick();
    end
  endtask
  task automatic do_frame();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    watch(10);
  endtask
  initial begin
    tick();
    tick();
    rst_pix = 1'b0;
    chk("rst_rd_x", $signed(rd_x), 1280);
    chk("rst_rd_y", $signed(rd_y), 0);
    chk("rst_rd_anim", rd_anim, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    cfg(0, 100, 320, -4, 0, 0);
    do_frame();
    chk("t1_busy_cycles", nb, 5);
    chk("t1_done_pulses", nd, 1);
    rd(0);
    chk("t1_x", $signed(rd_x), 96);
    chk("t1_y", $signed(rd_y), 320);
    chk("t1_anim", rd_anim, 0);
    cfg(1, -252, 0, -4, 0, 0);
    do_frame();
    rd(1);
    chk("t2_wrap_lo", $signed(rd_x), 1280);
    cfg(1, 1276, 0, 8, 0, 0);
    do_frame();
    rd(1);
    chk("t2_wrap_hi", $signed(rd_x), -255);
    rd(0);
    chk("t2_s0_x", $signed(rd_x), 88);
    cfg(2, 1020, 2, 8, -5, 1);
    cfg(3, 50, 0, -128, 0, 1);
    do_frame();
    rd(2);
    chk("t3_bounce_x", $signed(rd_x), 1024);
    chk("t3_bounce_y", $signed(rd_y), 0);
    rd(3);
    chk("t3_bounce_sat_x", $signed(rd_x), 0);
    do_frame();
    rd(2);
    chk("t3_after_x", $signed(rd_x), 1016);
    chk("t3_after_y", $signed(rd_y), 5);
    rd(3);
    chk("t3_sat_vel", $signed(rd_x), 127);
    rst_pix = 1'b1;
    tick();
    rst_pix = 1'b0;
    for (int i = 0; i < 16; i++) do_frame();
    rd(0);
    chk("t4_anim16_s0", rd_anim, 2);
    chk("t4_x_s0", $signed(rd_x), 1280);
    rd(3);
    chk("t4_anim16_s3", rd_anim, 2);
    for (int i = 0; i < 8; i++) do_frame();
    rd(1);
    chk("t4_anim24", rd_anim, 3);
    for (int i = 0; i < 8; i++) do_frame();
    rd(2);
    chk("t4_anim32", rd_anim, 0);
    chk("t4_overrun_clear", overrun, 0);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    tick();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    watch(12);
    chk("t5_overrun", overrun, 1);
    chk("t5_one_done", nd, 1);
    for (int i = 0; i < 6; i++) do_frame();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    tick();
    cfg(1, 500, 7, 3, 0, 0);
    watch(8);
    rd(1);
    chk("t5_coll_x", $signed(rd_x), 500);
    chk("t5_coll_y", $signed(rd_y), 7);
    chk("t5_coll_anim", rd_anim, 0);
    rd(0);
    chk("t5_step_s0", rd_anim, 1);
    cfg(0, 10, 20, 1, 1, 0);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    tick();
    chk("t6_pre_overrun", overrun, 1);
    rst_pix = 1'b1;
    tick();
    rst_pix = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_overrun", overrun, 0);
    watch(8);
    chk("t6_no_done", nd, 0);
    for (int i = 0; i < NSPR; i++) begin
      rd(i);
      chk($sformatf("t6_x%0d", i), $signed(rd_x), 1280);
      chk($sformatf("t6_y%0d", i), $signed(rd_y), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
